// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with trap/redirect/halt control and alignment masking.
// Define PC_RAS_EN to build the optional circular return-address stack.
module pc_sequencer #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned INCR       = 4,
    parameter int unsigned RAS_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic [ADDR_WIDTH-1:0] base_address_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_target_i,
    input  logic                  trap_valid_i,
    input  logic [ADDR_WIDTH-1:0] trap_vector_i,
    input  logic                  halt_req_i,
    input  logic                  resume_i,
    input  logic                  call_push_i,
    input  logic                  ret_pop_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  pc_valid_o,
    output logic [ADDR_WIDTH-1:0] pc_plus_incr_o,
    output logic                  halted_o,
    output logic                  misaligned_o,
    output logic                  ras_empty_o,
    output logic                  ras_underflow_o
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;
    localparam logic [ADDR_WIDTH-1:0] MASK = ADDR_WIDTH'(INCR - 1);

    state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, tgt, ras_top;
    logic mis_q, mis_d, run, load, push_req, pop_req, und_req, ras_empty;

    assign run = state_q == RUN;
    assign pc_plus_incr_o = pc_q + ADDR_WIDTH'(INCR);
    assign push_req = run & ~trap_valid_i & redirect_valid_i & call_push_i;
    assign pop_req = run & ~trap_valid_i & ~redirect_valid_i & ret_pop_i & ~ras_empty;
    assign und_req = run & ~trap_valid_i & ~redirect_valid_i & ret_pop_i & ras_empty;
    assign tgt = trap_valid_i ? trap_vector_i : redirect_valid_i ? redirect_target_i : ras_top;
    assign load = (run & (trap_valid_i | redirect_valid_i | pop_req)) | (state_q == HALTED & trap_valid_i);
    assign pc_d = load ? tgt & ~MASK : (run & ~halt_req_i & enable_i) ? pc_plus_incr_o : pc_q;
    assign mis_d = load & |(tgt & MASK);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= BOOT;
            pc_q    <= base_address_i;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = (~trap_valid_i & ~redirect_valid_i & ~pop_req & halt_req_i) ? HALTED : RUN;
            HALTED:  state_d = (trap_valid_i | resume_i) ? RUN : HALTED;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_o         = pc_q;
        pc_valid_o   = state_q == RUN;
        halted_o     = state_q == HALTED;
        misaligned_o = mis_q;
        ras_empty_o  = ras_empty;
    end

`ifdef PC_RAS_EN
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0] sp_q;
    logic [PW:0] cnt_q;
    logic und_q;

    assign ras_empty = cnt_q == '0;
    assign ras_top = ras_q[sp_q - 1'b1];
    assign ras_underflow_o = und_q;

    // sp_q points at the next free slot; wrapping over the oldest entry makes overflow free
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sp_q  <= '0;
            cnt_q <= '0;
            und_q <= 1'b0;
        end else begin
            und_q <= und_req;
            if (push_req) begin
                sp_q  <= sp_q + 1'b1;
                cnt_q <= (cnt_q == (PW+1)'(RAS_DEPTH)) ? cnt_q : cnt_q + 1'b1;
            end else if (pop_req) begin
                sp_q  <= sp_q - 1'b1;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && push_req) ras_q[sp_q] <= pc_plus_incr_o;
    end
`else
    logic unused_ras;
    assign ras_empty = 1'b1;
    assign ras_top = '0;
    assign ras_underflow_o = 1'b0;
    assign unused_ras = push_req ^ und_req ^ (RAS_DEPTH == 0);
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer; RAS vectors run only when PC_RAS_EN is defined.
module tb_pc_sequencer;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset, enable, redirect_valid, trap_valid, halt_req, resume, call_push, ret_pop;
    logic [15:0] base_address, redirect_target, trap_vector, pc, pc_plus_incr;
    logic pc_valid, halted, misaligned, ras_empty, ras_underflow;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .base_address_i(base_address),
        .redirect_valid_i(redirect_valid), .redirect_target_i(redirect_target),
        .trap_valid_i(trap_valid), .trap_vector_i(trap_vector), .halt_req_i(halt_req),
        .resume_i(resume), .call_push_i(call_push), .ret_pop_i(ret_pop),
        .pc_o(pc), .pc_valid_o(pc_valid), .pc_plus_incr_o(pc_plus_incr), .halted_o(halted),
        .misaligned_o(misaligned), .ras_empty_o(ras_empty), .ras_underflow_o(ras_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable = 0; redirect_valid = 0; trap_valid = 0; halt_req = 0;
        resume = 0; call_push = 0; ret_pop = 0;
    endtask

    task automatic go(input logic [15:0] a);
        redirect_valid = 1; redirect_target = a;
        step();
        redirect_valid = 0;
    endtask

    initial begin
        idle();
        reset = 1; base_address = 16'h0010; redirect_target = 0; trap_vector = 0;
        step(); step();
        check("rst_pc", pc, 16'h0010);
        check("rst_valid", pc_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_mis", misaligned, 0);
        check("rst_empty", ras_empty, 1);
        check("rst_und", ras_underflow, 0);
        reset = 0; enable = 1;
        step();
        check("boot_pc", pc, 16'h0010);
        check("boot_valid", pc_valid, 1);
        step(); check("seq1", pc, 16'h0014);
        step(); check("seq2", pc, 16'h0018);
        trap_valid = 1; trap_vector = 16'h0100; redirect_valid = 1; redirect_target = 16'h0200;
        step();
        check("trap_wins", pc, 16'h0100);
        check("trap_mis", misaligned, 0);
        trap_valid = 0; redirect_target = 16'h0203;
        step();
        check("redir_mask", pc, 16'h0200);
        check("redir_mis", misaligned, 1);
        idle();
        step();
        check("mis_pulse", misaligned, 0);
        check("hold_pc", pc, 16'h0200);
        go(16'h0020);
        halt_req = 1;
        step();
        check("halt_pc", pc, 16'h0020);
        check("halt_h", halted, 1);
        check("halt_valid", pc_valid, 0);
        halt_req = 0; enable = 1; redirect_valid = 1; redirect_target = 16'h0500;
        step();
        check("halt_ignore", pc, 16'h0020);
        check("halt_stay", halted, 1);
        redirect_valid = 0; resume = 1;
        step();
        check("resume_pc", pc, 16'h0020);
        check("resume_h", halted, 0);
        check("resume_valid", pc_valid, 1);
        resume = 0;
        step();
        check("resume_run", pc, 16'h0024);
        enable = 0; halt_req = 1;
        step();
        check("halt2", halted, 1);
        halt_req = 0; trap_valid = 1; trap_vector = 16'h0300;
        step();
        check("htrap_pc", pc, 16'h0300);
        check("htrap_h", halted, 0);
        check("htrap_valid", pc_valid, 1);
        trap_vector = 16'h0104; halt_req = 1;
        step();
        check("trap_halt_pc", pc, 16'h0104);
        check("trap_halt_h", halted, 0);
        idle();
        go(16'hFFFC);
        check("wrap_pre", pc, 16'hFFFC);
        check("wrap_plus", pc_plus_incr, 16'h0000);
        enable = 1;
        step();
        check("wrap_pc", pc, 16'h0000);
        enable = 0; ret_pop = 1;
        step();
        check("pop_empty_und", ras_underflow, RAS);
        check("pop_empty_pc", pc, 16'h0000);
        ret_pop = 0;
        step();
        check("und_pulse", ras_underflow, 0);
        go(16'h0040);
`ifdef PC_RAS_EN
        call_push = 1;
        go(16'h0400);
        call_push = 0;
        check("call_pc", pc, 16'h0400);
        check("call_nonempty", ras_empty, 0);
        ret_pop = 1;
        step();
        ret_pop = 0;
        check("ret_pc", pc, 16'h0044);
        check("ret_empty", ras_empty, 1);
        call_push = 1;
        for (int i = 0; i < 5; i++) go(16'h1000 + 16'(i * 16'h0100));
        call_push = 0;
        ret_pop = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("lifo_pc", pc, 16'h1304 - 16'(i * 16'h0100));
            check("lifo_und", ras_underflow, 0);
        end
        check("lifo_empty", ras_empty, 1);
        step();
        check("und5", ras_underflow, 1);
        check("und5_pc", pc, 16'h1004);
        ret_pop = 0;
        call_push = 1;
        for (int i = 0; i < 4; i++) go(16'h2000 + 16'(i * 16'h0010));
        call_push = 0;
        check("full_nonempty", ras_empty, 0);
`endif
        halt_req = 1;
        step();
        halt_req = 0;
        check("pre_rst_h", halted, 1);
        reset = 1; base_address = 16'h0080;
        step();
        check("mrst_pc", pc, 16'h0080);
        check("mrst_valid", pc_valid, 0);
        check("mrst_h", halted, 0);
        check("mrst_empty", ras_empty, 1);
        reset = 0;
        step();
        check("mrst_boot", pc, 16'h0080);
        check("mrst_run", pc_valid, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
